// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a two-entry skid buffer, forwarding taps and
// a saturating back-pressure counter.
module mem_wb_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 2,
  parameter int STALL_CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   WB_in,
  input  logic [DATA_W-1:0]   Read_data_in,
  input  logic [DATA_W-1:0]   ALUresult_in,
  input  logic [REG_AW-1:0]   write_register_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   WB_out,
  output logic [DATA_W-1:0]   wb_data,
  output logic [REG_AW-1:0]   write_register_out,
  output logic                fwd_valid,
  output logic [REG_AW-1:0]   fwd_reg,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [STALL_CW-1:0] stall_cnt
);

  logic                main_valid;
  logic                skid_valid;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [REG_AW-1:0]   skid_reg;
  logic [DATA_W-1:0]   in_data;
  logic                accept;
  logic                consume;

  // Write-back mux is resolved on entry so both slots hold the final value.
  assign in_data   = WB_in[0] ? Read_data_in : ALUresult_in;
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready;
  assign consume   = main_valid && out_ready;

  assign fwd_valid = main_valid && WB_out[1] && (write_register_out != '0);
  assign fwd_reg   = write_register_out;
  assign fwd_data  = wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid         <= 1'b0;
      skid_valid         <= 1'b0;
      WB_out             <= '0;
      wb_data            <= '0;
      write_register_out <= '0;
      skid_ctrl          <= '0;
      skid_data          <= '0;
      skid_reg           <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        WB_out             <= skid_ctrl;
        wb_data            <= skid_data;
        write_register_out <= skid_reg;
        skid_valid         <= 1'b0;
      end else if (accept) begin
        WB_out             <= WB_in;
        wb_data            <= in_data;
        write_register_out <= write_register_in;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        WB_out             <= WB_in;
        wb_data            <= in_data;
        write_register_out <= write_register_in;
        main_valid         <= 1'b1;
      end else begin
        skid_ctrl  <= WB_in;
        skid_data  <= in_data;
        skid_reg   <= write_register_in;
        skid_valid <= 1'b1;
      end
    end
  end

  // Counts stalled cycles regardless of flush; pins at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed vector table, stall saturation
// sequence, and randomized traffic against a queue-based reference model.
module tb_mem_wb_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_valid;
  logic [CW-1:0] WB_in, WB_out;
  logic [DW-1:0] Read_data_in, ALUresult_in, wb_data, fwd_data;
  logic [AW-1:0] write_register_in, write_register_out, fwd_reg;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .STALL_CW(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_in(WB_in), .Read_data_in(Read_data_in), .ALUresult_in(ALUresult_in),
    .write_register_in(write_register_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_out(WB_out), .wb_data(wb_data), .write_register_out(write_register_out),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [CW-1:0] wb;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
  } ent_t;

  typedef struct {
    logic          rst, flush, iv, ordy;
    logic [CW-1:0] wb;
    logic [DW-1:0] rd, alu;
    logic [AW-1:0] wr;
    logic          e_ov, e_ir;
    logic [DW-1:0] e_wbd;
    logic          e_fv;
    int            e_st;
  } vec_t;

  ent_t q[$];
  int   m_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered FIFO of at most two entries.
  task automatic model_step(input logic r, f, iv, ordy, input logic [CW-1:0] wb,
                            input logic [DW-1:0] rd, alu, input logic [AW-1:0] wr);
    ent_t e;
    bit acc, con;
    e.wb = wb;
    e.d  = wb[0] ? rd : alu;
    e.r  = wr;
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !ordy && m_cnt < (2**SW - 1)) m_cnt++;
      if (f) q.delete();
      else begin
        acc = iv && (q.size() < 2);
        con = (q.size() > 0) && ordy;
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  endtask

  task automatic model_check();
    bit v;
    v = q.size() > 0;
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("stall_cnt", DW'(stall_cnt), DW'(m_cnt));
    if (v) begin
      chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, q[0].wb[1] && (q[0].r != 0)});
      chk("WB_out", DW'(WB_out), DW'(q[0].wb));
      chk("wb_data", wb_data, q[0].d);
      chk("write_register_out", DW'(write_register_out), DW'(q[0].r));
      chk("fwd_reg", DW'(fwd_reg), DW'(q[0].r));
      chk("fwd_data", fwd_data, q[0].d);
    end else begin
      chk("fwd_valid", {31'b0, fwd_valid}, 32'd0);
    end
  endtask

  task automatic cycle(input logic r, f, iv, ordy, input logic [CW-1:0] wb,
                       input logic [DW-1:0] rd, alu, input logic [AW-1:0] wr);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    WB_in = wb; Read_data_in = rd; ALUresult_in = alu; write_register_in = wr;
    @(posedge clk);
    model_step(r, f, iv, ordy, wb, rd, alu, wr);
    #1;
    model_check();
  endtask

  task automatic add(input logic r, f, iv, ordy, input logic [CW-1:0] wb,
                     input logic [DW-1:0] rd, alu, input logic [AW-1:0] wr,
                     input logic e_ov, e_ir, input logic [DW-1:0] e_wbd,
                     input logic e_fv, input int e_st);
    vec_t v;
    v = '{r, f, iv, ordy, wb, rd, alu, wr, e_ov, e_ir, e_wbd, e_fv, e_st};
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    WB_in = '0; Read_data_in = '0; ALUresult_in = '0; write_register_in = '0;

    //   rst f iv or wb       rd            alu        wr   ov ir wbd           fv st
    add(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,     0,   0, 1, 32'h0,        0, 0);
    add(0, 0, 1, 1, 3'b011, 32'hDEADBEEF, 32'h10,    5,   1, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 3'b000, 32'h0,        32'h0,     0,   0, 1, 32'h0,        0, 0);
    add(0, 0, 1, 0, 3'b010, 32'hAAAA,     32'h1,     3,   1, 1, 32'h1,        1, 0);
    add(0, 0, 1, 0, 3'b010, 32'hBBBB,     32'h2,     4,   1, 0, 32'h1,        1, 1);
    add(0, 0, 1, 0, 3'b010, 32'hCCCC,     32'h3,     8,   1, 0, 32'h1,        1, 2);
    add(0, 0, 0, 1, 3'b000, 32'h0,        32'h0,     0,   1, 1, 32'h2,        1, 2);
    add(0, 0, 0, 1, 3'b000, 32'h0,        32'h0,     0,   0, 1, 32'h0,        0, 2);
    add(0, 0, 1, 0, 3'b010, 32'h0,        32'h11,    6,   1, 1, 32'h11,       1, 2);
    add(0, 0, 1, 0, 3'b010, 32'h0,        32'h22,    7,   1, 0, 32'h11,       1, 3);
    add(0, 1, 1, 0, 3'b010, 32'h0,        32'h33,    9,   0, 1, 32'h0,        0, 4);
    add(0, 0, 0, 1, 3'b000, 32'h0,        32'h0,     0,   0, 1, 32'h0,        0, 4);
    add(0, 0, 1, 1, 3'b010, 32'h0,        32'h55,    0,   1, 1, 32'h55,       0, 4);
    add(0, 0, 1, 1, 3'b111, 32'h1234,     32'h99,    31,  1, 1, 32'h1234,     1, 4);
    add(0, 0, 1, 1, 3'b101, 32'h77,       32'h88,    7,   1, 1, 32'h77,       0, 4);
    add(0, 0, 0, 1, 3'b000, 32'h0,        32'h0,     0,   0, 1, 32'h0,        0, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].wb,
            tbl[i].rd, tbl[i].alu, tbl[i].wr);
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_ir});
      chk($sformatf("vec%0d fwd_valid", i), {31'b0, fwd_valid}, {31'b0, tbl[i].e_fv});
      chk($sformatf("vec%0d stall_cnt", i), DW'(stall_cnt), DW'(tbl[i].e_st));
      if (tbl[i].e_ov) chk($sformatf("vec%0d wb_data", i), wb_data, tbl[i].e_wbd);
    end

    // Stall counter saturation, then reset clears it.
    cycle(1, 0, 0, 0, 3'b000, 0, 0, 0);
    cycle(0, 0, 1, 0, 3'b010, 0, 32'h42, 2);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 3'b000, 0, 0, 0);
    chk("sat stall_cnt", DW'(stall_cnt), 32'd15);
    chk("sat out_valid", {31'b0, out_valid}, 32'd1);
    cycle(1, 0, 1, 0, 3'b010, 0, 32'h43, 3);
    chk("rst stall_cnt", DW'(stall_cnt), 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst WB_out", DW'(WB_out), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 1, $urandom_range(99) < 4,
            $urandom_range(99) < 70, $urandom_range(99) < 55,
            CW'($urandom), $urandom, $urandom, AW'($urandom_range(3) == 0 ? 0 : $urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of memory read data, ALU result and write-back data.
REQ-002 Parameter REG_AW, default 5, width of register-file write address.
REQ-003 Parameter CTRL_W, default 2 (minimum 2), width of WB control bundle; bit 1 = RegWrite, bit 0 = MemtoReg, bits above 1 passed through unchanged.
REQ-004 Parameter STALL_CW, default 8, width of stall counter.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discard all held and incoming entries.
REQ-008 in_valid  input  1  MEM stage offers an entry.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 WB_in  input  CTRL_W  WB control bundle.
REQ-011 Read_data_in  input  DATA_W  memory read data.
REQ-012 ALUresult_in  input  DATA_W  ALU result.
REQ-013 write_register_in  input  REG_AW  destination register.
REQ-014 out_valid  output  1  WB entry present.
REQ-015 out_ready  input  1  WB stage consumes entry.
REQ-016 WB_out  output  CTRL_W  registered control bundle.
REQ-017 wb_data  output  DATA_W  registered write-back value.
REQ-018 write_register_out  output  REG_AW  registered destination.
REQ-019 fwd_valid  output  1  forwarding hit qualifier.
REQ-020 fwd_reg  output  REG_AW  forwarding destination (equals write_register_out).
REQ-021 fwd_data  output  DATA_W  forwarding value (equals wb_data).
REQ-022 stall_cnt  output  STALL_CW  saturating count of back-pressure cycles.

Function
REQ-023 Storage: two entries, main (drives outputs) and skid; each with valid bit; in_ready = !skid_valid (registered state only, no combinational path from out_ready).
REQ-024 Accept = in_valid && in_ready; consume = out_valid && out_ready; out_valid = main_valid.
REQ-025 On accept: wb_data captured as WB_in[0] ? Read_data_in : ALUresult_in; WB_in and write_register_in captured alongside.
REQ-026 Accept with main empty, or main consumed same cycle with skid empty: entry loads into main next cycle (latency 1).
REQ-027 Accept with main full and not consumed: entry loads into skid; in_ready drops next cycle.
REQ-028 Consume with skid full: skid moves into main next cycle, skid_valid clears; no accept possible that cycle.
REQ-029 Consume with skid empty and no accept: main_valid clears.
REQ-030 Entries leave in strict arrival order; no entry duplicated or dropped except by flush/rst.
REQ-031 flush: both valid bits clear next cycle; entry offered same cycle is dropped; flush overrides accept and consume; data fields may hold stale values.
REQ-032 fwd_valid = main_valid && WB_out[1] && (write_register_out != 0).
REQ-033 stall_cnt increments by 1 each cycle with out_valid && !out_ready; saturates at all-ones; never wraps; unaffected by flush.
REQ-034 When out_valid = 0, WB_out[1] still holds last value but consumers qualify with out_valid; fwd_valid is 0.

Reset
REQ-035 rst takes priority over flush and all handshakes.
REQ-036 On rst: main_valid = 0, skid_valid = 0, in_ready = 1 next cycle, WB_out = 0, wb_data = 0, write_register_out = 0, fwd_valid = 0, stall_cnt = 0.
REQ-037 rst asserted mid-operation discards both entries and any entry offered that cycle.

Verification
REQ-038 Pass-through: out_ready=1, in_valid=1, WB_in=2'b11, Read_data_in=0xDEADBEEF, ALUresult_in=0x10, write_register_in=5 -> next cycle out_valid=1, wb_data=0xDEADBEEF, fwd_valid=1, fwd_reg=5.
REQ-039 Skid: out_ready=0, entries A(ALU 0x1,MemtoReg=0) then B(ALU 0x2) -> in_ready=0 after B; raise out_ready -> wb_data 0x1 then 0x2 on consecutive cycles, in_ready returns 1.
REQ-040 Flush: both entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry never appears.
REQ-041 Zero register: WB_in=2'b10, write_register_in=0 -> out_valid=1, fwd_valid=0.
REQ-042 Stall saturation, STALL_CW=4: hold out_valid with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; rst -> stall_cnt=0, out_valid=0.
